// File: rtl/neighbour_scanner.sv
// neighbour_scanner: scans a (MAX_i+1) x (MAX_j+1) grid one row at a time
// through a three-row window. For every cell in raster order it presents the
// cell state and its live-neighbour count. Cells outside the grid count as dead.
module neighbour_scanner #(
    parameter int MAX_i = 19,
    parameter int MAX_j = 14
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    output logic           rd_en,
    output logic [3:0]     rd_y,
    input  logic [0:MAX_i] rd_row,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4:0]     sum_neighbours,
    output logic           cell_alive,
    output logic [4:0]     cell_x,
    output logic [3:0]     cell_y,
    output logic           busy,
    output logic           done
);

    localparam int LW = $clog2(MAX_j + 2);
    localparam logic [4:0]    X_LAST  = 5'(MAX_i);
    localparam logic [3:0]    Y_LAST  = 4'(MAX_j);
    localparam logic [LW-1:0] LD_LAST = LW'(MAX_j);

    typedef enum logic [2:0] {IDLE, LOAD, CAPT, EMIT, DONE} state_t;

    state_t         state, state_nx;
    logic [0:MAX_i] above, cur, below;
    logic [LW-1:0]  ld_row;
    logic [4:0]     x;
    logic [3:0]     y;
    logic [3:0]     nsum;

    // State register
    always_ff @(posedge clk) begin
        if (!clr) state <= IDLE;
        else      state <= state_nx;
    end

    // Row window, row loader and cell counters
    always_ff @(posedge clk) begin
        if (!clr) begin
            above  <= '0;
            cur    <= '0;
            below  <= '0;
            ld_row <= '0;
            x      <= '0;
            y      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        above  <= '0;
                        cur    <= '0;
                        below  <= '0;
                        ld_row <= '0;
                    end
                end
                CAPT: begin
                    above  <= cur;
                    cur    <= below;
                    // Past the last row the window is filled with dead cells
                    below  <= (ld_row <= LD_LAST) ? rd_row : '0;
                    ld_row <= ld_row + LW'(1);
                    if (ld_row != '0) begin
                        x <= '0;
                        y <= 4'(ld_row - LW'(1));
                    end
                end
                EMIT: begin
                    if (out_ready && (x < X_LAST)) x <= x + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Neighbour count for column x; edge columns drop the out-of-grid side
    always_comb begin
        nsum = '0;
        if (x != 5'd0)
            nsum = nsum + 4'(above[x - 5'd1]) + 4'(cur[x - 5'd1]) + 4'(below[x - 5'd1]);
        nsum = nsum + 4'(above[x]) + 4'(below[x]);
        if (x != X_LAST)
            nsum = nsum + 4'(above[x + 5'd1]) + 4'(cur[x + 5'd1]) + 4'(below[x + 5'd1]);
    end

    // Next-state and output decode
    always_comb begin
        state_nx       = state;
        rd_en          = 1'b0;
        rd_y           = '0;
        out_valid      = 1'b0;
        sum_neighbours = '0;
        cell_alive     = 1'b0;
        cell_x         = '0;
        cell_y         = '0;
        busy           = (state != IDLE);
        done           = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                if (ld_row <= LD_LAST) begin
                    rd_en = 1'b1;
                    rd_y  = 4'(ld_row);
                end
                state_nx = CAPT;
            end
            CAPT: begin
                state_nx = (ld_row == '0) ? LOAD : EMIT;
            end
            EMIT: begin
                out_valid      = 1'b1;
                cell_x         = x;
                cell_y         = y;
                cell_alive     = cur[x];
                sum_neighbours = {1'b0, nsum};
                if (out_ready && (x == X_LAST))
                    state_nx = (y == Y_LAST) ? DONE : LOAD;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_neighbour_scanner.sv
// Scoreboard bench for neighbour_scanner: expected cells are queued when a
// frame is started and a negedge monitor pops and compares every transfer.
module tb_neighbour_scanner;

    localparam int MAX_i = 19;
    localparam int MAX_j = 14;
    localparam int NCELL = (MAX_i + 1) * (MAX_j + 1);

    logic           clk;
    logic           clr;
    logic           start;
    logic           rd_en;
    logic [3:0]     rd_y;
    logic [0:MAX_i] rd_row;
    logic           out_valid;
    logic           out_ready;
    logic [4:0]     sum_neighbours;
    logic           cell_alive;
    logic [4:0]     cell_x;
    logic [3:0]     cell_y;
    logic           busy;
    logic           done;

    neighbour_scanner #(.MAX_i(MAX_i), .MAX_j(MAX_j)) dut (
        .clk(clk), .clr(clr), .start(start), .rd_en(rd_en), .rd_y(rd_y),
        .rd_row(rd_row), .out_valid(out_valid), .out_ready(out_ready),
        .sum_neighbours(sum_neighbours), .cell_alive(cell_alive),
        .cell_x(cell_x), .cell_y(cell_y), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grid memory: row data one cycle after rd_en, junk ones otherwise
    logic [0:MAX_i] grid_mem [0:15];
    always @(posedge clk) rd_row <= rd_en ? grid_mem[rd_y] : '1;

    typedef struct packed {
        logic [4:0] x;
        logic [3:0] y;
        logic       alive;
        logic [4:0] sum;
    } cell_t;

    cell_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_xfer   = 0;
    int    n_done   = 0;
    bit    rnd_ready = 1'b0;
    logic [4:0] obs_sum   [0:15][0:31];
    logic       obs_alive [0:15][0:31];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    function automatic cell_t model(input int cx, input int cy);
        cell_t c;
        int s = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                int xx = cx + dx;
                int yy = cy + dy;
                if (!(dx == 0 && dy == 0) && xx >= 0 && xx <= MAX_i && yy >= 0 && yy <= MAX_j)
                    s += int'(grid_mem[4'(yy)][5'(xx)]);
            end
        c.x     = 5'(cx);
        c.y     = 4'(cy);
        c.alive = grid_mem[4'(cy)][5'(cx)];
        c.sum   = 5'(s);
        return c;
    endfunction

    task automatic clear_grid();
        for (int r = 0; r < 16; r++) grid_mem[4'(r)] = '0;
    endtask

    task automatic set_cell(input int cx, input int cy);
        grid_mem[4'(cy)][5'(cx)] = 1'b1;
    endtask

    task automatic queue_frame();
        for (int cy = 0; cy <= MAX_j; cy++)
            for (int cx = 0; cx <= MAX_i; cx++)
                exp_q.push_back(model(cx, cy));
        n_xfer = 0;
    endtask

    // Consumer ready: constant high or random back-pressure
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: transfer scoreboard, stall stability and idle-output checks
    initial begin
        cell_t cur_c;
        cell_t held;
        cell_t e;
        bit    held_v = 1'b0;
        forever begin
            @(negedge clk);
            cur_c = {cell_x, cell_y, cell_alive, sum_neighbours};
            if (done) n_done++;
            if (clr && held_v) begin
                check("stall_valid_held", int'(out_valid), 1);
                check("stall_outputs_held", int'(cur_c), int'(held));
            end
            held_v = clr && out_valid && !out_ready;
            held   = cur_c;
            if (clr && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_transfer", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("transfer_cell", int'(cur_c), int'(e));
                    obs_sum[cell_y][cell_x]   = sum_neighbours;
                    obs_alive[cell_y][cell_x] = cell_alive;
                    n_xfer++;
                end
            end
            if (!out_valid) check("outputs_zero_outside_emit", int'(cur_c), 0);
            check("rd_en_with_valid", int'(rd_en && out_valid), 0);
        end
    end

    task automatic run_frame(input string tag, input bit timed, input bit extra_start);
        int cyc   = 0;
        int first = -1;
        int d0    = n_done;
        queue_frame();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (!done && cyc < 5000) begin
            @(posedge clk);
            #1 cyc++;
            if (out_valid && first < 0) first = cyc;
            if (extra_start && cyc == 50) start = 1'b1;
            if (extra_start && cyc == 51) start = 1'b0;
        end
        check({tag, "_done_seen"}, int'(done), 1);
        if (timed) begin
            check({tag, "_first_valid_latency"}, first, 4);
            check({tag, "_frame_cycles"}, cyc, 332);
        end
        @(posedge clk);
        #1 check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_done_one_cycle"}, int'(done), 0);
        @(negedge clk);
        check({tag, "_transfers"}, n_xfer, NCELL);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_done_count"}, n_done - d0, 1);
        exp_q.delete();
    endtask

    initial begin
        int d0;
        int guard;
        clr   = 1'b0;
        start = 1'b1;
        clear_grid();
        repeat (3) @(posedge clk);
        #1 check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(out_valid), 0);
        check("reset_rd_en", int'(rd_en), 0);
        check("reset_done", int'(done), 0);
        start = 1'b0;
        clr   = 1'b1;
        @(posedge clk);
        #1 check("reset_beats_start", int'(busy), 0);

        // All-zero grid, with timing checks
        run_frame("zero", 1'b1, 1'b0);

        // Blinker
        clear_grid();
        set_cell(4, 5); set_cell(5, 5); set_cell(6, 5);
        run_frame("blinker", 1'b1, 1'b0);
        check("blinker_5_4_sum", int'(obs_sum[4][5]), 3);
        check("blinker_5_4_alive", int'(obs_alive[4][5]), 0);
        check("blinker_5_5_sum", int'(obs_sum[5][5]), 2);
        check("blinker_5_5_alive", int'(obs_alive[5][5]), 1);
        check("blinker_4_5_sum", int'(obs_sum[5][4]), 1);
        check("blinker_5_6_sum", int'(obs_sum[6][5]), 3);

        // Corner, no wrap
        clear_grid();
        set_cell(0, 0); set_cell(1, 0); set_cell(0, 1);
        run_frame("corner", 1'b1, 1'b0);
        check("corner_1_1_sum", int'(obs_sum[1][1]), 3);
        check("corner_0_0_sum", int'(obs_sum[0][0]), 2);
        check("corner_0_0_alive", int'(obs_alive[0][0]), 1);
        check("corner_last_sum", int'(obs_sum[14][19]), 0);
        check("corner_19_0_sum", int'(obs_sum[0][19]), 0);

        // Blinker under random back-pressure
        clear_grid();
        set_cell(4, 5); set_cell(5, 5); set_cell(6, 5);
        set_cell(19, 14); set_cell(18, 13);
        rnd_ready = 1'b1;
        run_frame("backpressure", 1'b0, 1'b0);
        check("bp_5_5_sum", int'(obs_sum[5][5]), 2);
        check("bp_19_14_sum", int'(obs_sum[14][19]), 1);
        rnd_ready = 1'b0;

        // Mid-frame reset during row 7
        clear_grid();
        set_cell(0, 0); set_cell(1, 0); set_cell(0, 1);
        queue_frame();
        d0 = n_done;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        guard = 0;
        while (!(out_valid && cell_y == 4'd7) && guard < 2000) begin
            @(posedge clk);
            #1 guard++;
        end
        check("reach_row7", int'(out_valid && cell_y == 4'd7), 1);
        clr = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(out_valid), 0);
        check("abort_rd_en", int'(rd_en), 0);
        clr = 1'b1;
        repeat (30) @(posedge clk);
        #1 check("abort_not_resumed", int'(busy), 0);
        check("abort_no_done", n_done - d0, 0);
        run_frame("after_reset", 1'b1, 1'b0);
        check("after_reset_1_1_sum", int'(obs_sum[1][1]), 3);

        // Start pulsed while busy is ignored
        clear_grid();
        set_cell(10, 7);
        run_frame("busy_start", 1'b0, 1'b1);
        d0 = n_done;
        repeat (400) @(posedge clk);
        #1 check("busy_start_no_second_frame", int'(busy), 0);
        check("busy_start_no_extra_done", n_done - d0, 0);
        check("busy_start_9_6_sum", int'(obs_sum[6][9]), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neighbour_scanner.md
NEIGHBOUR_SCANNER -- requirements
Module: neighbour_scanner

Interface
REQ-001 Parameter MAX_i, default 19, shall be the highest column index (grid width MAX_i+1).
REQ-002 Parameter MAX_j, default 14, shall be the highest row index (grid height MAX_j+1).
REQ-003 clk  in  1  shall be the single clock; all state updates occur on its rising edge.
REQ-004 clr  in  1  shall be the reset: synchronous and active-low.
REQ-005 start  in  1  shall be a one-cycle request to begin one frame scan.
REQ-006 rd_en  out  1  shall be the grid read strobe.
REQ-007 rd_y  out  4  shall be the grid row address.
REQ-008 rd_row  in  [0:MAX_i]  shall be the row data returned one cycle after rd_en; bit x is the cell in column x.
REQ-009 out_valid  out  1  shall indicate that the cell result outputs are valid.
REQ-010 out_ready  in  1  shall be the consumer accept signal.
REQ-011 sum_neighbours  out  5  shall be the live-neighbour count 0..8; bit 4 is always 0.
REQ-012 cell_alive  out  1  shall be the current state of cell (cell_x, cell_y).
REQ-013 cell_x  out  5  and  cell_y  out  4  shall be the cell coordinates.
REQ-014 busy  out  1  shall be high in every state except IDLE.
REQ-015 done  out  1  shall be a one-cycle pulse at the end of a frame.

Function
REQ-016 Internal row buffers above, cur and below, each [0:MAX_i], plus ld_row (0..MAX_j+1), y and x counters, shall hold scan state.
REQ-017 FSM states shall be IDLE, LOAD, CAPT, EMIT and DONE.
REQ-018 IDLE: start=1 shall clear above/cur/below, set ld_row=0 and go to LOAD; start in any other state shall be ignored.
REQ-019 LOAD: rd_en=1 and rd_y=ld_row shall be driven when ld_row<=MAX_j, otherwise rd_en=0; next state is CAPT.
REQ-020 CAPT shall perform above<=cur, cur<=below, below<=(ld_row<=MAX_j ? rd_row : 0), ld_row<=ld_row+1.
REQ-021 CAPT exit: if the old ld_row==0, the FSM shall go to LOAD; otherwise it shall go to EMIT with x=0 and y=old ld_row-1.
REQ-022 EMIT shall drive out_valid=1, cell_x=x, cell_y=y, cell_alive=cur[x], and sum_neighbours = above[x-1..x+1] + cur[x-1] + cur[x+1] + below[x-1..x+1].
REQ-023 Column indices below 0 or above MAX_i shall contribute 0; the grid does not wrap and edges are dead.
REQ-024 All EMIT outputs shall hold stable while out_valid=1 and out_ready=0.
REQ-025 A transfer shall occur when out_valid and out_ready are both high. On transfer with x<MAX_i, x shall increment. On transfer with x==MAX_i: if y==MAX_j, go to DONE; otherwise go to LOAD.
REQ-026 DONE shall assert done=1 for exactly one cycle and then return to IDLE.
REQ-027 Cells shall be emitted in raster order, (0,0) through (MAX_i,MAX_j), once each per frame.
REQ-028 With out_ready held high, first out_valid shall occur 4 cycles after the start-accept edge, and a frame shall take 332 cycles from leaving IDLE to the DONE state (defaults).
REQ-029 Outside EMIT, out_valid, sum_neighbours, cell_alive, cell_x and cell_y shall be 0.
REQ-030 rd_en shall be 0 outside LOAD.

Reset
REQ-031 clr=0 at a clock edge shall force IDLE, zero all buffers and counters, and drive every output to 0, including mid-frame; the aborted frame shall not be resumed.
REQ-032 clr=0 shall take priority over start and out_ready in the same cycle.

Verification
REQ-033 All-zero grid, start, ready=1 -> 300 transfers, each sum=0 and alive=0; done exactly once; busy low afterwards.
REQ-034 Blinker: cells (4,5),(5,5),(6,5) alive -> (5,4) sum=3 alive=0; (5,5) sum=2 alive=1; (4,5) sum=1; (5,6) sum=3.
REQ-035 Corner check: cells (0,0),(1,0),(0,1) alive -> (1,1) sum=3; (0,0) sum=2; (MAX_i,MAX_j) sum=0 (no wrap).
REQ-036 Back-pressure: out_ready toggles randomly -> outputs hold while stalled; the transfer sequence is identical to the ready=1 run; no cell is duplicated or skipped.
REQ-037 clr=0 for one cycle during row 7 -> next cycle busy=0 and out_valid=0; a fresh start yields a complete, correct frame.
REQ-038 start pulsed while busy -> ignored; exactly one done per accepted start.
